mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port, fixed-latency unified memory between two requesters of the multi-cycle CPU.
- Port 0 is instruction fetch (driven in the IF state); port 1 is data access (driven in the MEM state for lw/sw).
- The block sequences every memory transaction: grant, memory strobe, latency count, response.
- It sits between the control/datapath and the memory macro, and replaces the separate instruction and data memory paths.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory.
- DATA_W, 32, data width.
- LATENCY, 2, memory read latency in cycles (legal range 1..15); the counter is 4 bits.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held high until if_gnt.
- if_addr  in  ADDR_W  fetch address (read only).
- if_gnt  out  1  one-cycle pulse: fetch request accepted.
- if_rvalid  out  1  one-cycle pulse: if_rdata valid.
- if_rdata  out  DATA_W  fetched word.
- d_req  in  1  data request; held high until d_gnt.
- d_we  in  1  1 = write (sw), 0 = read (lw).
- d_addr  in  ADDR_W  data address.
- d_wdata  in  DATA_W  store data.
- d_gnt  out  1  one-cycle pulse: data request accepted.
- d_rvalid  out  1  one-cycle pulse: read data valid, or write complete.
- d_rdata  out  DATA_W  loaded word.
- mem_en  out  1  memory strobe, high for one cycle per transaction.
- mem_we  out  1  memory write enable; qualified by mem_en.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  valid exactly LATENCY cycles after the mem_en cycle.
- busy  out  1  high while in the ACCESS state.

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE, cnt = 0.
  - Every output = 0, including the rdata, mem_addr and mem_wdata registers.
  - The last-grant flag resets to data.
- All outputs are registered.
- FSM states: IDLE, ACCESS.
- IDLE, at a rising edge where if_req or d_req is high:
  - Choose the winner. Fixed priority by default: d_req beats if_req.
  - For the winner: gnt = 1, mem_en = 1, mem_we = d_we (0 for fetch).
  - Latch addr and wdata into mem_addr and mem_wdata. Latch owner.
  - cnt = LATENCY-1. Go to ACCESS. busy = 1.
- IDLE with no request: all pulses 0; stay in IDLE.
- ACCESS:
  - gnt and mem_en drop after one cycle. mem_addr, mem_wdata and mem_we hold their values.
  - Requests are ignored; the loser waits with req held.
  - At each edge: if cnt == 0, capture mem_rdata into the owner's rdata, pulse the owner's rvalid for one cycle, set busy = 0 and go to IDLE; otherwise decrement cnt.
- Latency: from the edge that samples req to rvalid is exactly LATENCY edges.
- Throughput: at most one transaction per LATENCY+1 cycles. The next grant can be sampled no earlier than the edge after rvalid.
- Writes: d_rvalid pulses as a completion ack. d_rdata is still updated with mem_rdata; its value is don't-care.
- The rdata registers hold their value until the next response to the same port.
- Requester dropping req after gnt: no effect; the transaction completes.
- Requester holding req after gnt: treated as a new request once the arbiter is back in IDLE.
- Reset asserted during ACCESS: the transaction is aborted, no rvalid is issued, and everything returns to reset values.
- A write is never issued twice: mem_en is high for exactly one cycle per grant.

Optional Feature:
- Macro: MEM_PORT_ARB_RR_EN.
- Defined: round-robin arbitration. When both requests are high in IDLE, grant the port not granted last. A single requester is always granted. The last-grant flag updates on every grant.
- Undefined: fixed priority, data over fetch. No last-grant flag is implemented.

Decomposition:
- Shared package holds:
  - state encoding (IDLE = 1'b0, ACCESS = 1'b1);
  - owner encoding (OWN_IF = 0, OWN_D = 1);
  - default widths;
  - LATENCY_MAX = 15.
- One natural sub-module, mem_port_arb_pick: combinational winner selection, given if_req, d_req and the last-grant flag, with the RR variant under the macro.
- Counter and FSM stay in the top level.

Test Plan:
- Reset mid-transaction, with LATENCY = 2: after if_req with if_addr = 0x100 is granted, drive reset low before rvalid. Required: no rvalid; all outputs 0 immediately. After reset is released, the if_req is re-granted.
- Single fetch, LATENCY = 2: if_req with if_addr = 0x10, mem_rdata = 0xDEADBEEF. Required: if_gnt and mem_en (mem_we = 0, mem_addr = 0x10) at edge T; if_rvalid with if_rdata = 0xDEADBEEF at edge T+2; busy high for 2 cycles.
- Simultaneous requests, fixed priority: if_req and d_req (read, 0x200) both high. Required: d_gnt first; if_gnt at the edge after d_rvalid.
- Store: d_req, d_we = 1, d_addr = 0x40, d_wdata = 0x12345678. Required: exactly one mem_en cycle with mem_we = 1 and the matching addr/wdata; d_rvalid LATENCY cycles later.
- RR enabled: both requests held high continuously for 4 transactions. Required: grant order D, IF, D, IF, with no starvation.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified memory port arbiter: FSM and owner
// encodings, default widths and latency limits.
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int LATENCY_DEF = 2;
    localparam int LATENCY_MAX = 15;
    localparam int CNT_W       = 4;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_e;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Combinational winner selection between fetch and data requesters.
// MEM_PORT_ARB_RR_EN selects round-robin; otherwise data beats fetch.
module mem_port_arb_pick
    import mem_port_arbiter_pkg::*;
(
    input  logic   if_req_i,
    input  logic   d_req_i,
`ifdef MEM_PORT_ARB_RR_EN
    input  owner_e last_own_i,
`endif
    output logic   valid_o,
    output owner_e owner_o
);

    always_comb begin
        valid_o = if_req_i | d_req_i;
        owner_o = OWN_D;
`ifdef MEM_PORT_ARB_RR_EN
        // On contention the port that did not win last time goes first.
        if (if_req_i && d_req_i) begin
            owner_o = (last_own_i == OWN_D) ? OWN_IF : OWN_D;
        end else if (if_req_i) begin
            owner_o = OWN_IF;
        end
`else
        if (if_req_i && !d_req_i) begin
            owner_o = OWN_IF;
        end
`endif
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency single-port memory between instruction fetch and
// data access. Optional round-robin arbitration via MEM_PORT_ARB_RR_EN.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int LATENCY = LATENCY_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    // Valid LATENCY is 1..LATENCY_MAX so the reload fits the 4-bit counter.
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    state_e            state_q, state_d;
    owner_e            owner_q, owner_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              if_gnt_q, if_gnt_d;
    logic              d_gnt_q, d_gnt_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic   pick_valid;
    owner_e pick_owner;

`ifdef MEM_PORT_ARB_RR_EN
    owner_e last_q, last_d;
`endif

    mem_port_arb_pick u_pick (
        .if_req_i   (if_req),
        .d_req_i    (d_req),
`ifdef MEM_PORT_ARB_RR_EN
        .last_own_i (last_q),
`endif
        .valid_o    (pick_valid),
        .owner_o    (pick_owner)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        if_gnt_d    = 1'b0;
        d_gnt_d     = 1'b0;
        if_rvalid_d = 1'b0;
        d_rvalid_d  = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
`ifdef MEM_PORT_ARB_RR_EN
        last_d      = last_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    state_d  = ST_ACCESS;
                    owner_d  = pick_owner;
                    cnt_d    = CNT_INIT;
                    mem_en_d = 1'b1;
`ifdef MEM_PORT_ARB_RR_EN
                    last_d   = pick_owner;
`endif
                    if (pick_owner == OWN_D) begin
                        d_gnt_d     = 1'b1;
                        mem_we_d    = d_we;
                        mem_addr_d  = d_addr;
                        mem_wdata_d = d_wdata;
                    end else begin
                        if_gnt_d    = 1'b1;
                        mem_we_d    = 1'b0;
                        mem_addr_d  = if_addr;
                    end
                end
            end
            ST_ACCESS: begin
                // Requests are ignored here; a losing requester keeps req held.
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    if (owner_q == OWN_D) begin
                        d_rvalid_d = 1'b1;
                        d_rdata_d  = mem_rdata;
                    end else begin
                        if_rvalid_d = 1'b1;
                        if_rdata_d  = mem_rdata;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            owner_q     <= OWN_IF;
            cnt_q       <= '0;
            if_gnt_q    <= 1'b0;
            d_gnt_q     <= 1'b0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            cnt_q       <= cnt_d;
            if_gnt_q    <= if_gnt_d;
            d_gnt_q     <= d_gnt_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

`ifdef MEM_PORT_ARB_RR_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_q <= OWN_D;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign if_gnt    = if_gnt_q;
    assign d_gnt     = d_gnt_q;
    assign if_rvalid = if_rvalid_q;
    assign d_rvalid  = d_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_en    = mem_en_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    // busy is the registered FSM state, so it doubles as the state observer.
    assign busy      = (state_q == ST_ACCESS);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with LATENCY = 2 and a small memory
// model whose read data is only valid in the capture cycle.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk;
    logic          reset;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          d_req;
    logic          d_we;
    logic [AW-1:0] d_addr;
    logic [DW-1:0] d_wdata;
    logic          d_gnt;
    logic          d_rvalid;
    logic [DW-1:0] d_rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          busy;

    int n_tests = 0;
    int n_fail  = 0;
    int en_cnt  = 0;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LATENCY(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_gnt    (if_gnt),
        .if_rvalid (if_rvalid),
        .if_rdata  (if_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // memory model: strobe seen at negedge, data driven only for the cycle
    // that ends LATENCY (= 2) edges after the grant edge
    logic [DW-1:0] mem_arr [0:255];
    logic          en_p  = 1'b0;
    logic          en_p2 = 1'b0;
    logic [7:0]    rd_idx = 8'd0;

    always @(negedge clk) begin
        en_p2 <= en_p;
        en_p  <= mem_en;
        if (mem_en) begin
            rd_idx <= mem_addr[9:2];
            en_cnt <= en_cnt + 1;
            if (mem_we) mem_arr[mem_addr[9:2]] <= mem_wdata;
        end
    end

    assign mem_rdata = en_p2 ? mem_arr[rd_idx] : 32'hBAD0_BAD0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pulses"}, {57'd0, if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, busy}, 64'd0);
        check({tag, "_if_rdata"}, {32'd0, if_rdata}, 64'd0);
        check({tag, "_d_rdata"}, {32'd0, d_rdata}, 64'd0);
        check({tag, "_mem_addr"}, {32'd0, mem_addr}, 64'd0);
        check({tag, "_mem_wdata"}, {32'd0, mem_wdata}, 64'd0);
    endtask

    logic [0:0] exp_q[$];
    int         grants;
    int         budget;
    int         last_gnt_cyc;
    int         en_before;
    logic [0:0] exp_own;

    initial begin
        for (int i = 0; i < 256; i++) mem_arr[i] = 32'h0;
        mem_arr[4]   = 32'hDEAD_BEEF;   // 0x010
        mem_arr[64]  = 32'hA5A5_0100;   // 0x100
        mem_arr[128] = 32'hCAFE_0200;   // 0x200

        reset   = 1'b0;
        if_req  = 1'b0;
        if_addr = '0;
        d_req   = 1'b0;
        d_we    = 1'b0;
        d_addr  = '0;
        d_wdata = '0;
        tick();
        tick();
        check_all_zero("reset");
        reset = 1'b1;
        tick();
        check("idle_no_req", {63'd0, busy | mem_en}, 64'd0);

        // reset during ACCESS
        if_req  = 1'b1;
        if_addr = 32'h100;
        tick();
        check("mid_gnt", {62'd0, if_gnt, mem_en}, 64'h3);
        check("mid_addr", {32'd0, mem_addr}, 64'h100);
        tick();
        check("mid_busy", {63'd0, busy}, 64'd1);
        reset = 1'b0;
        #1;
        check_all_zero("mid_reset");
        tick();
        check("mid_no_rvalid", {63'd0, if_rvalid}, 64'd0);
        reset = 1'b1;
        tick();
        check("mid_regrant", {62'd0, if_gnt, mem_en}, 64'h3);
        check("mid_regrant_addr", {32'd0, mem_addr}, 64'h100);
        if_req = 1'b0;
        tick();
        tick();
        check("mid_rvalid", {63'd0, if_rvalid}, 64'd1);
        check("mid_rdata", {32'd0, if_rdata}, 64'hA5A5_0100);

        // single fetch
        if_req  = 1'b1;
        if_addr = 32'h10;
        tick();
        check("f_gnt", {60'd0, if_gnt, d_gnt, mem_en, mem_we}, 64'b1010);
        check("f_addr", {32'd0, mem_addr}, 64'h10);
        check("f_busy0", {63'd0, busy}, 64'd1);
        if_req = 1'b0;
        tick();
        check("f_mid", {60'd0, if_gnt, mem_en, if_rvalid, busy}, 64'b0001);
        tick();
        check("f_rvalid", {62'd0, if_rvalid, busy}, 64'b10);
        check("f_rdata", {32'd0, if_rdata}, 64'hDEAD_BEEF);
        tick();
        check("f_pulse", {63'd0, if_rvalid}, 64'd0);
        check("f_hold", {32'd0, if_rdata}, 64'hDEAD_BEEF);

        // simultaneous requests: data first, fetch at the edge after d_rvalid
        if_req = 1'b1;
        if_addr = 32'h10;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h200;
        tick();
        check("s_first", {62'd0, d_gnt, if_gnt}, 64'b10);
        check("s_addr", {32'd0, mem_addr}, 64'h200);
        d_req = 1'b0;
        tick();
        check("s_wait", {62'd0, if_gnt, d_gnt}, 64'd0);
        tick();
        check("s_d_rvalid", {62'd0, d_rvalid, if_gnt}, 64'b10);
        check("s_d_rdata", {32'd0, d_rdata}, 64'hCAFE_0200);
        tick();
        check("s_if_gnt", {62'd0, if_gnt, d_rvalid}, 64'b10);
        check("s_if_addr", {32'd0, mem_addr}, 64'h10);
        if_req = 1'b0;
        tick();
        tick();
        check("s_if_rvalid", {63'd0, if_rvalid}, 64'd1);
        check("s_if_rdata", {32'd0, if_rdata}, 64'hDEAD_BEEF);
        check("s_d_hold", {32'd0, d_rdata}, 64'hCAFE_0200);
        tick();

        // both held for 4 transactions; last winner was fetch
`ifdef MEM_PORT_ARB_RR_EN
        exp_q = '{1'b1, 1'b0, 1'b1, 1'b0};
`else
        exp_q = '{1'b1, 1'b1, 1'b1, 1'b1};
`endif
        if_req = 1'b1;
        d_req  = 1'b1;
        d_we   = 1'b0;
        grants = 0;
        budget = 0;
        last_gnt_cyc = 0;
        while (grants < 4 && budget < 40) begin
            tick();
            budget++;
            if (if_gnt || d_gnt) begin
                exp_own = exp_q.pop_front();
                check($sformatf("rr_owner%0d", grants), {63'd0, d_gnt}, {63'd0, exp_own});
                if (grants > 0) check($sformatf("rr_gap%0d", grants), 64'(budget - last_gnt_cyc), 64'd3);
                last_gnt_cyc = budget;
                grants++;
            end
        end
        if (grants < 4) check("rr_timeout", 64'(grants), 64'd4);
        if_req = 1'b0;
        d_req  = 1'b0;
        budget = 0;
        while (busy && budget < 10) begin
            tick();
            budget++;
        end
        check("rr_idle", {63'd0, busy}, 64'd0);
        tick();

        // store: one strobe, ack LATENCY cycles later, then read it back
        en_before = en_cnt;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 32'h40;
        d_wdata = 32'h1234_5678;
        tick();
        check("w_gnt", {61'd0, d_gnt, mem_en, mem_we}, 64'b111);
        check("w_addr", {32'd0, mem_addr}, 64'h40);
        check("w_wdata", {32'd0, mem_wdata}, 64'h1234_5678);
        d_req = 1'b0;
        d_we  = 1'b0;
        tick();
        check("w_hold", {62'd0, mem_en, mem_we}, 64'b01);
        tick();
        check("w_ack", {63'd0, d_rvalid}, 64'd1);
        tick();
        tick();
        check("w_one_strobe", 64'(en_cnt - en_before), 64'd1);
        check("w_mem", {32'd0, mem_arr[16]}, 64'h1234_5678);
        d_req  = 1'b1;
        d_addr = 32'h40;
        tick();
        check("r_gnt", {62'd0, d_gnt, mem_we}, 64'b10);
        d_req = 1'b0;
        tick();
        tick();
        check("r_rvalid", {63'd0, d_rvalid}, 64'd1);
        check("r_rdata", {32'd0, d_rdata}, 64'h1234_5678);
        check("r_if_hold", {32'd0, if_rdata}, 64'hDEAD_BEEF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
